// File: rtl/impulse_arbiter_if.sv
// Handshake bundle between the two pulse-length producers, the arbiter and
// the impulse generator. The arbiter is the slave side of this bundle; the
// surrounding environment (producers plus generator) is the master side.
interface impulse_arbiter_if;
  // Source A request channel
  logic [7:0] numero_a;
  logic       dav_a_;
  logic       rfd_a;
  // Source B request channel
  logic [7:0] numero_b;
  logic       dav_b_;
  logic       rfd_b;
  // Generator channel, the arbiter acts as producer here
  logic [7:0] numero_out;
  logic       dav_out_;
  logic       rfd_in;

  modport slave (
    input  numero_a, dav_a_, numero_b, dav_b_, rfd_in,
    output rfd_a, rfd_b, numero_out, dav_out_
  );

  modport master (
    output numero_a, dav_a_, numero_b, dav_b_, rfd_in,
    input  rfd_a, rfd_b, numero_out, dav_out_
  );
endinterface

// File: rtl/impulse_arbiter.sv
// Two-source round-robin arbiter sharing one impulse generator.
// One pulse length at a time is captured from source A or B into BUF and
// then offered to the generator over an active-low dav / rfd handshake.
// Every output comes straight from a flop; the handshake outputs are
// registered copies of the decode of the next state, so they change on the
// same edge as the state and no input reaches an output combinationally.
module impulse_arbiter (
  input  logic                    clock,
  input  logic                    reset_,
  impulse_arbiter_if.slave        bus,
  output logic                    owner,
  output logic                    busy,
  output logic [7:0]              served_a,
  output logic [7:0]              served_b
);

  typedef enum logic [2:0] {
    S_ACCEPT  = 3'd0,
    S_RELEASE = 3'd1,
    S_READY   = 3'd2,
    S_OFFER   = 3'd3,
    S_CLOSE   = 3'd4
  } star_t;

  // Arbitration rule: a lone requester wins; on a tie the favoured source wins.
  function automatic logic pick_winner(input logic req_a, input logic req_b,
                                       input logic pri);
    logic win;
    if (req_a && req_b) begin
      win = pri;
    end else if (req_b) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

  star_t      star_q, star_d;
  logic [7:0] buf_q, buf_d;
  logic       sel_q, sel_d;
  logic       pri_q, pri_d;
  logic [7:0] served_a_q, served_a_d;
  logic [7:0] served_b_q, served_b_d;

  // Registered copies of the Moore decode of the state
  logic       rfd_a_q, rfd_a_d;
  logic       rfd_b_q, rfd_b_d;
  logic       dav_out_q, dav_out_d;
  logic       busy_q, busy_d;

  logic       win_s;
  logic       src_dav_s;

  // Next-state logic: arbitration, capture, source release, generator handshake
  always_comb begin
    star_d     = star_q;
    buf_d      = buf_q;
    sel_d      = sel_q;
    pri_d      = pri_q;
    served_a_d = served_a_q;
    served_b_d = served_b_q;
    win_s      = 1'b0;
    src_dav_s  = 1'b1;

    case (star_q)
      S_ACCEPT: begin
        if (!bus.dav_a_ || !bus.dav_b_) begin
          win_s = pick_winner(!bus.dav_a_, !bus.dav_b_, pri_q);
          if (win_s) begin
            buf_d = bus.numero_b;
          end else begin
            buf_d = bus.numero_a;
          end
          sel_d  = win_s;
          pri_d  = ~win_s;
          star_d = S_RELEASE;
        end else begin
          star_d = S_ACCEPT;
        end
      end

      S_RELEASE: begin
        // Wait for the granted source to withdraw its request
        if (sel_q) begin
          src_dav_s = bus.dav_b_;
        end else begin
          src_dav_s = bus.dav_a_;
        end
        if (src_dav_s) begin
          star_d = S_READY;
        end else begin
          star_d = S_RELEASE;
        end
      end

      S_READY: begin
        if (bus.rfd_in) begin
          star_d = S_OFFER;
        end else begin
          star_d = S_READY;
        end
      end

      S_OFFER: begin
        // Generator taking the value is the delivery point that gets counted
        if (!bus.rfd_in) begin
          if (sel_q) begin
            served_b_d = served_b_q + 8'd1;
          end else begin
            served_a_d = served_a_q + 8'd1;
          end
          star_d = S_CLOSE;
        end else begin
          star_d = S_OFFER;
        end
      end

      S_CLOSE: begin
        star_d = S_ACCEPT;
      end

      default: begin
        star_d = S_ACCEPT;
      end
    endcase
  end

  // Output decode of the upcoming state, registered alongside the state
  always_comb begin
    rfd_a_d   = 1'b1;
    rfd_b_d   = 1'b1;
    dav_out_d = 1'b1;
    busy_d    = 1'b1;

    if (star_d == S_RELEASE) begin
      rfd_a_d = sel_d;
      rfd_b_d = ~sel_d;
    end else begin
      rfd_a_d = 1'b1;
      rfd_b_d = 1'b1;
    end

    if (star_d == S_OFFER) begin
      dav_out_d = 1'b0;
    end else begin
      dav_out_d = 1'b1;
    end

    if (star_d == S_ACCEPT) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
  end

  // State, data and counter registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star_q     <= S_ACCEPT;
      buf_q      <= 8'd0;
      sel_q      <= 1'b0;
      pri_q      <= 1'b0;
      served_a_q <= 8'd0;
      served_b_q <= 8'd0;
    end else begin
      star_q     <= star_d;
      buf_q      <= buf_d;
      sel_q      <= sel_d;
      pri_q      <= pri_d;
      served_a_q <= served_a_d;
      served_b_q <= served_b_d;
    end
  end

  // Handshake and status output flops, idle values while in reset
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      rfd_a_q   <= 1'b1;
      rfd_b_q   <= 1'b1;
      dav_out_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      rfd_a_q   <= rfd_a_d;
      rfd_b_q   <= rfd_b_d;
      dav_out_q <= dav_out_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rfd_a      = rfd_a_q;
  assign bus.rfd_b      = rfd_b_q;
  assign bus.dav_out_   = dav_out_q;
  assign bus.numero_out = buf_q;
  assign owner          = sel_q;
  assign busy           = busy_q;
  assign served_a       = served_a_q;
  assign served_b       = served_b_q;

endmodule

// File: tb/tb_impulse_arbiter.sv
// Bench for impulse_arbiter. Producers push the value they offer into a
// per-source expected queue; a monitor pops and compares whenever the
// generator handshake presents a value, and keeps its own delivery counts.
module tb_impulse_arbiter;
  localparam int LIM = 2000;

  logic       clock;
  logic       reset_;
  logic       owner;
  logic       busy;
  logic [7:0] served_a;
  logic [7:0] served_b;

  impulse_arbiter_if bus ();

  impulse_arbiter dut (
    .clock    (clock),
    .reset_   (reset_),
    .bus      (bus),
    .owner    (owner),
    .busy     (busy),
    .served_a (served_a),
    .served_b (served_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic       exp_owner[$];

  logic gen_hold = 1'b0;
  int   gphase   = 0;
  int   gdelay   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Generator: ready when idle, takes an offered value after a random delay
  initial begin
    bus.rfd_in = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        gphase     = 0;
        bus.rfd_in = !gen_hold;
      end else begin
        case (gphase)
          0: begin
            bus.rfd_in = !gen_hold;
            if (!gen_hold && !bus.dav_out_) begin
              gdelay = $urandom_range(0, 3);
              gphase = 1;
            end
          end
          1: begin
            if (gdelay == 0) begin
              bus.rfd_in = 1'b0;
              gphase     = 2;
            end else begin
              gdelay--;
            end
          end
          default: begin
            if (bus.dav_out_) gphase = 0;
          end
        endcase
      end
    end
  end

  // Monitor: compares each offered value and each delivery count
  initial begin
    logic       prev_dav;
    logic [7:0] m_sa;
    logic [7:0] m_sb;
    prev_dav = 1'b1;
    m_sa     = 8'd0;
    m_sb     = 8'd0;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        prev_dav = 1'b1;
        m_sa     = 8'd0;
        m_sb     = 8'd0;
        exp_a.delete();
        exp_b.delete();
        exp_owner.delete();
      end else begin
        if (prev_dav && !bus.dav_out_) begin
          if (exp_owner.size() > 0) check("owner_order", owner, exp_owner.pop_front());
          if (owner == 1'b0) begin
            if (exp_a.size() == 0) begin
              checks++; failures++;
              $display("FAIL spurious_a actual=%0h required=none", bus.numero_out);
            end else begin
              check("value_a", bus.numero_out, exp_a.pop_front());
            end
          end else begin
            if (exp_b.size() == 0) begin
              checks++; failures++;
              $display("FAIL spurious_b actual=%0h required=none", bus.numero_out);
            end else begin
              check("value_b", bus.numero_out, exp_b.pop_front());
            end
          end
        end
        if (!prev_dav && bus.dav_out_) begin
          if (owner) m_sb = m_sb + 8'd1;
          else       m_sa = m_sa + 8'd1;
          check("served_a", served_a, m_sa);
          check("served_b", served_b, m_sb);
        end
        prev_dav = bus.dav_out_;
      end
    end
  end

  // Producer side: offer one value, wait for capture, withdraw, wait for rfd
  task automatic send(input logic src, input logic [7:0] v);
    int n;
    @(negedge clock);
    if (src) begin
      exp_b.push_back(v); bus.numero_b = v; bus.dav_b_ = 1'b0;
    end else begin
      exp_a.push_back(v); bus.numero_a = v; bus.dav_a_ = 1'b0;
    end
    n = 0;
    do begin @(negedge clock); n++; end
    while ((src ? bus.rfd_b : bus.rfd_a) && n < LIM);
    check(src ? "capture_b" : "capture_a", src ? bus.rfd_b : bus.rfd_a, 1'b0);
    if (src) bus.dav_b_ = 1'b1; else bus.dav_a_ = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end
    while (!(src ? bus.rfd_b : bus.rfd_a) && n < LIM);
    check(src ? "release_b" : "release_a", src ? bus.rfd_b : bus.rfd_a, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < LIM && !(exp_a.size() == 0 && exp_b.size() == 0 && !busy &&
                        gphase == 0 && bus.dav_out_)) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, (n < LIM), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int na;
    int nb;
    reset_       = 1'b0;
    bus.numero_a = 8'd0;
    bus.numero_b = 8'd0;
    bus.dav_a_   = 1'b1;
    bus.dav_b_   = 1'b1;
    do_reset();

    // Reset values
    check("rst_rfd_a", bus.rfd_a, 1'b1);
    check("rst_rfd_b", bus.rfd_b, 1'b1);
    check("rst_dav_out", bus.dav_out_, 1'b1);
    check("rst_numero_out", bus.numero_out, 8'd0);
    check("rst_owner", owner, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_served_a", served_a, 8'd0);
    check("rst_served_b", served_b, 8'd0);

    // Single request from A
    @(negedge clock);
    exp_a.push_back(8'd5);
    bus.numero_a = 8'd5;
    bus.dav_a_   = 1'b0;
    @(posedge clock); #1;
    check("single_rfd_a", bus.rfd_a, 1'b0);
    check("single_buf", bus.numero_out, 8'd5);
    check("single_busy", busy, 1'b1);
    @(negedge clock);
    bus.dav_a_ = 1'b1;
    wait_idle("single");
    check("single_served_a", served_a, 8'd1);

    // Collision straight after reset: A favoured, B served next
    do_reset();
    exp_a.push_back(8'd3);
    exp_b.push_back(8'd7);
    exp_owner.push_back(1'b0);
    exp_owner.push_back(1'b1);
    bus.numero_a = 8'd3; bus.dav_a_ = 1'b0;
    bus.numero_b = 8'd7; bus.dav_b_ = 1'b0;
    @(posedge clock); #1;
    check("coll_rfd_a", bus.rfd_a, 1'b0);
    check("coll_rfd_b", bus.rfd_b, 1'b1);
    check("coll_buf_a", bus.numero_out, 8'd3);
    @(negedge clock);
    bus.dav_a_ = 1'b1;
    n = 0;
    while (bus.rfd_b && n < LIM) begin @(negedge clock); n++; end
    check("coll_b_captured", bus.rfd_b, 1'b0);
    check("coll_buf_b", bus.numero_out, 8'd7);
    check("coll_a_first", exp_a.size(), 0);
    bus.dav_b_ = 1'b1;
    wait_idle("coll");

    // Fairness under continuous demand
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_owner.push_back(1'b0);
      exp_owner.push_back(1'b1);
    end
    fork
      for (int i = 0; i < 3; i++) send(1'b0, 8'($urandom_range(0, 255)));
      for (int j = 0; j < 3; j++) send(1'b1, 8'($urandom_range(0, 255)));
    join
    wait_idle("fair");
    check("fair_served_a", served_a, 8'd3);
    check("fair_served_b", served_b, 8'd3);
    check("fair_order_done", exp_owner.size(), 0);

    // Slow generator: hold in S_READY until rfd_in rises
    @(negedge clock);
    gen_hold = 1'b1;
    repeat (2) @(negedge clock);
    send(1'b0, 8'h5A);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("slow_dav_out", bus.dav_out_, 1'b1);
      check("slow_busy", busy, 1'b1);
    end
    gen_hold = 1'b0;
    n = 0;
    do begin @(posedge clock); n++; end while (!bus.rfd_in && n < 10);
    #1;
    check("slow_offer", bus.dav_out_, 1'b0);
    wait_idle("slow");

    // Randomised traffic from both sources
    na = $urandom_range(10, 20);
    nb = $urandom_range(10, 20);
    fork
      for (int i = 0; i < na; i++) begin
        repeat ($urandom_range(0, 4)) @(negedge clock);
        send(1'b0, (i == 0) ? 8'd0 : 8'($urandom_range(0, 255)));
      end
      for (int j = 0; j < nb; j++) begin
        repeat ($urandom_range(0, 4)) @(negedge clock);
        send(1'b1, (j == 0) ? 8'd255 : 8'($urandom_range(0, 255)));
      end
    join
    wait_idle("rand");

    // Reset while the generator is being offered a value
    send(1'b0, 8'hC3);
    n = 0;
    while (bus.dav_out_ && n < LIM) begin @(negedge clock); n++; end
    check("rst_offer_reached", bus.dav_out_, 1'b0);
    #2 reset_ = 1'b0;
    #1;
    check("rst_mid_dav_out", bus.dav_out_, 1'b1);
    check("rst_mid_rfd_a", bus.rfd_a, 1'b1);
    check("rst_mid_rfd_b", bus.rfd_b, 1'b1);
    check("rst_mid_numero", bus.numero_out, 8'd0);
    check("rst_mid_served_a", served_a, 8'd0);
    check("rst_mid_served_b", served_b, 8'd0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    send(1'b0, 8'h11);
    wait_idle("post_rst");
    check("post_rst_served_a", served_a, 8'd1);
    check("post_rst_served_b", served_b, 8'd0);

    // Counter wrap: 256 deliveries from A
    do_reset();
    for (int i = 0; i < 255; i++) send(1'b0, 8'($urandom_range(0, 255)));
    wait_idle("wrap255");
    check("wrap_before_a", served_a, 8'd255);
    check("wrap_before_b", served_b, 8'd0);
    send(1'b0, 8'hEE);
    wait_idle("wrap256");
    check("wrap_after_a", served_a, 8'd0);
    check("wrap_after_b", served_b, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
